rvfi_check_seq: RTL and testbench
=================================

RVFI_CHECK_SEQ -- requirements
Module: rvfi_check_seq

Interface
REQ-001 Parameter NRET, default 1: number of RVFI retirement channels.
REQ-002 Parameter ILEN, default 32: instruction width per channel.
REQ-003 Parameter CHECK_DEPTH, default 8: 1-based retirement ordinal at which the check fires (legal range 1..255).
REQ-004 Parameter CNT_W, default 8: width of the retirement counter.
REQ-005 Parameter FILTER_MASK, default 0: instruction bit mask; used only with the filter feature.
REQ-006 Parameter FILTER_MATCH, default 0: instruction match value; used only with the filter feature.
REQ-007 Port clock  in  1: single clock; all state updates on its rising edge.
REQ-008 Port resetn  in  1: synchronous, active-low reset.
REQ-009 Port rvfi_valid  in  NRET: per-channel retire strobe; a lower channel index is earlier in program order.
REQ-010 Port rvfi_insn  in  NRET*ILEN: per-channel instruction, packed with channel 0 in the LSBs.
REQ-011 Port rvfi_halt  in  NRET: per-channel halt flag.
REQ-012 Port check  out  1: single-cycle strobe telling the instruction checker to evaluate this cycle.
REQ-013 Port check_chan  out  NRET: one-hot channel selected for the check; zero when check is 0.
REQ-014 Port retire_cnt  out  CNT_W: registered count of retirements seen so far; saturates.
REQ-015 Port done  out  1: registered; high after the check has fired.
REQ-016 Port aborted  out  1: registered; high when a halt retired before any check fired.

Function
REQ-017 States: IDLE, COUNT, DONE, ABORT; encoded in 2 bits.
REQ-018 IDLE lasts exactly the first cycle after reset release, then COUNT is entered unconditionally; retirements in IDLE are ignored.
REQ-019 COUNT: a valid channel k is assigned ordinal retire_cnt + (number of valid channels with index <= k).
REQ-020 COUNT: channel k is eligible when valid, ordinal >= CHECK_DEPTH, and it passes the filter (REQ-032/033).
REQ-021 check and check_chan are combinational, with zero latency in the same cycle as rvfi_valid: the lowest-index eligible channel is selected, and check = |check_chan.
REQ-022 At most one check pulse is produced per reset epoch; after a pulse the next state is DONE.
REQ-023 retire_cnt increments by popcount(rvfi_valid) in COUNT and saturates at 2^CNT_W-1 with no wrap-around; it holds in DONE and ABORT.
REQ-024 Halt: if any valid channel has rvfi_halt in COUNT and no channel is eligible at or below the halting channel index, the next state is ABORT and check stays 0.
REQ-025 Halt on a channel above the selected channel in the same cycle: the check still fires and the next state is DONE.
REQ-026 Halt on the selected channel itself: the check fires and the next state is DONE.
REQ-027 DONE and ABORT are terminal: check = 0, and only reset leaves these states.
REQ-028 done = (state == DONE); aborted = (state == ABORT); both are registered.

Reset
REQ-029 When resetn = 0 at a clock edge: state := IDLE, retire_cnt := 0, done := 0, aborted := 0.
REQ-030 While resetn = 0: check = 0 and check_chan = 0, combinationally.
REQ-031 Reset asserted mid-COUNT discards all progress; counting restarts from ordinal 1.

Configuration
REQ-032 With macro RVFI_CHECK_SEQ_FILTER_EN defined, a channel passes the filter only if (insn & FILTER_MASK) == FILTER_MATCH; non-matching retirements still count.
REQ-033 Without the macro, every channel passes the filter and FILTER_MASK/FILTER_MATCH are unused.

Structure
REQ-034 Package rvfi_check_seq_pkg: state enum typedef; the popcount function; the CNT_W default.
REQ-035 One sub-module, rvfi_check_seq_pick, is combinational: it computes per-channel ordinals, eligibility, and the lowest-index one-hot pick.

Verification
REQ-036 NRET=1, DEPTH=3: retire on cycles 2,3,4 -> check pulses on the third retirement only, done=1 the next cycle, retire_cnt=3.
REQ-037 NRET=2, DEPTH=3: both channels valid on 2 successive cycles -> check_chan=2'b01 on the second cycle, retire_cnt=4.
REQ-038 NRET=2, DEPTH=2, retire_cnt=0, both valid, halt on ch1 -> check_chan=2'b10, done=1, aborted=0.
REQ-039 DEPTH=5, halt on retirement 2 -> no check ever fires, aborted=1, retire_cnt=2.
REQ-040 Filter enabled, MASK=0x7F, MATCH=0x33, DEPTH=1: insn 0x13 then 0x33 -> check fires on 0x33 only, retire_cnt=2.
REQ-041 CNT_W=3, DEPTH=7 with the filter never matching, 10 retirements -> retire_cnt stays at 7, no check; resetn=0 for one cycle -> all outputs return to 0.

Source files
------------

// File: rtl/rvfi_check_seq_pkg.sv
// Shared types and helpers for the RVFI check sequencer.
package rvfi_check_seq_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rvfi_check_seq_pick.sv
// Per-channel ordinal/eligibility and lowest-index one-hot pick (combinational).
// Honours RVFI_CHECK_SEQ_FILTER_EN for the instruction match filter.
module rvfi_check_seq_pick #(
  parameter int              NRET         = 1,
  parameter int              ILEN         = 32,
  parameter int              CHECK_DEPTH  = 8,
  parameter int              CNT_W        = 8,
  parameter logic [ILEN-1:0] FILTER_MASK  = '0,
  parameter logic [ILEN-1:0] FILTER_MATCH = '0
) (
  input  logic [NRET-1:0]      valid,
  input  logic [NRET*ILEN-1:0] insn,
  input  logic [NRET-1:0]      halt,
  input  logic [CNT_W-1:0]     retire_cnt,
  output logic [NRET-1:0]      pick,
  output logic                 halt_abort
);

  // Wide enough that count + channel index never wraps before comparing with the depth.
  localparam int OW = CNT_W + 9;
  localparam logic [OW-1:0] DEPTH_W = OW'(CHECK_DEPTH);

  logic [NRET-1:0] pass;

  for (genvar gi = 0; gi < NRET; gi++) begin : g_filter
`ifdef RVFI_CHECK_SEQ_FILTER_EN
    assign pass[gi] = (insn[gi*ILEN +: ILEN] & FILTER_MASK) == FILTER_MATCH;
`else
    assign pass[gi] = 1'b1;
`endif
  end

`ifndef RVFI_CHECK_SEQ_FILTER_EN
  logic unused_filter;
  assign unused_filter = ^{insn, FILTER_MASK, FILTER_MATCH};
`endif

  // A halt aborts only if no eligible channel sits at or below it in program order.
  always_comb begin
    logic [OW-1:0] ord;
    logic          seen;
    logic          elig;
    pick       = '0;
    halt_abort = 1'b0;
    seen       = 1'b0;
    ord        = OW'(retire_cnt);
    for (int k = 0; k < NRET; k++) begin
      ord  = ord + OW'(valid[k]);
      elig = valid[k] && pass[k] && (ord >= DEPTH_W);
      if (elig && !seen) begin
        pick[k] = 1'b1;
      end
      seen = seen | elig;
      if (valid[k] && halt[k] && !seen) begin
        halt_abort = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvfi_check_seq.sv
// RVFI check sequencer: fires one check strobe at the CHECK_DEPTH-th retirement.
// Optional instruction filter enabled by macro RVFI_CHECK_SEQ_FILTER_EN.
module rvfi_check_seq
  import rvfi_check_seq_pkg::*;
#(
  parameter int              NRET         = 1,
  parameter int              ILEN         = 32,
  parameter int              CHECK_DEPTH  = 8,
  parameter int              CNT_W        = CNT_W_DEFAULT,
  parameter logic [ILEN-1:0] FILTER_MASK  = '0,
  parameter logic [ILEN-1:0] FILTER_MATCH = '0
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [NRET*ILEN-1:0] rvfi_insn,
  input  logic [NRET-1:0]      rvfi_halt,
  output logic                 check,
  output logic [NRET-1:0]      check_chan,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic                 done,
  output logic                 aborted
);

  localparam int SW = CNT_W + 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             done_reg, aborted_reg;
  logic [NRET-1:0]  pick;
  logic             halt_abort;
  logic [SW-1:0]    sum;

  rvfi_check_seq_pick #(
    .NRET         (NRET),
    .ILEN         (ILEN),
    .CHECK_DEPTH  (CHECK_DEPTH),
    .CNT_W        (CNT_W),
    .FILTER_MASK  (FILTER_MASK),
    .FILTER_MATCH (FILTER_MATCH)
  ) u_pick (
    .valid      (rvfi_valid),
    .insn       (rvfi_insn),
    .halt       (rvfi_halt),
    .retire_cnt (cnt_reg),
    .pick       (pick),
    .halt_abort (halt_abort)
  );

  // Strobe is gated by reset combinationally so nothing leaks while resetn is low.
  assign check_chan = (resetn && state_reg == ST_COUNT) ? pick : '0;
  assign check      = |check_chan;
  assign retire_cnt = cnt_reg;
  assign done       = done_reg;
  assign aborted    = aborted_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sum        = SW'(cnt_reg) + SW'(popcount(32'(rvfi_valid)));
    case (state_reg)
      ST_IDLE:  state_next = ST_COUNT;
      ST_COUNT: begin
        cnt_next = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
        if (check) begin
          state_next = ST_DONE;
        end else if (halt_abort) begin
          state_next = ST_ABORT;
        end
      end
      default:  state_next = state_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      done_reg    <= (state_next == ST_DONE);
      aborted_reg <= (state_next == ST_ABORT);
    end
  end

endmodule

// File: tb/tb_rvfi_check_seq.sv
// Directed bench for rvfi_check_seq over several parameterisations, with a queue of expected check strobes.
module tb_rvfi_check_seq;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  // A: NRET=1 DEPTH=3
  logic vA = 0, hA = 0, cA, chA, dA, aA;
  logic [31:0] iA = 0;
  logic [7:0] cntA;
  // B: NRET=2 DEPTH=3
  logic [1:0] vB = 0, hB = 0, chB;
  logic cB, dB, aB;
  logic [63:0] iB = 0;
  logic [7:0] cntB;
  // C: NRET=2 DEPTH=2
  logic [1:0] vC = 0, hC = 0, chC;
  logic cC, dC, aC;
  logic [63:0] iC = 0;
  logic [7:0] cntC;
  // D: NRET=1 DEPTH=5
  logic vD = 0, hD = 0, cD, chD, dD, aD;
  logic [31:0] iD = 0;
  logic [7:0] cntD;
  // E: NRET=1 CNT_W=3 DEPTH=9 (unreachable with a saturating 3-bit count)
  logic vE = 0, hE = 0, cE, chE, dE, aE;
  logic [31:0] iE = 0;
  logic [2:0] cntE;

  rvfi_check_seq #(.NRET(1), .CHECK_DEPTH(3)) u_a (
    .clock(clock), .resetn(resetn), .rvfi_valid(vA), .rvfi_insn(iA), .rvfi_halt(hA),
    .check(cA), .check_chan(chA), .retire_cnt(cntA), .done(dA), .aborted(aA));
  rvfi_check_seq #(.NRET(2), .CHECK_DEPTH(3)) u_b (
    .clock(clock), .resetn(resetn), .rvfi_valid(vB), .rvfi_insn(iB), .rvfi_halt(hB),
    .check(cB), .check_chan(chB), .retire_cnt(cntB), .done(dB), .aborted(aB));
  rvfi_check_seq #(.NRET(2), .CHECK_DEPTH(2)) u_c (
    .clock(clock), .resetn(resetn), .rvfi_valid(vC), .rvfi_insn(iC), .rvfi_halt(hC),
    .check(cC), .check_chan(chC), .retire_cnt(cntC), .done(dC), .aborted(aC));
  rvfi_check_seq #(.NRET(1), .CHECK_DEPTH(5)) u_d (
    .clock(clock), .resetn(resetn), .rvfi_valid(vD), .rvfi_insn(iD), .rvfi_halt(hD),
    .check(cD), .check_chan(chD), .retire_cnt(cntD), .done(dD), .aborted(aD));
  rvfi_check_seq #(.NRET(1), .CNT_W(3), .CHECK_DEPTH(9)) u_e (
    .clock(clock), .resetn(resetn), .rvfi_valid(vE), .rvfi_insn(iE), .rvfi_halt(hE),
    .check(cE), .check_chan(chE), .retire_cnt(cntE), .done(dE), .aborted(aE));

`ifdef RVFI_CHECK_SEQ_FILTER_EN
  logic vF = 0, hF = 0, cF, chF, dF, aF;
  logic [31:0] iF = 0;
  logic [7:0] cntF;
  rvfi_check_seq #(.NRET(1), .CHECK_DEPTH(1), .FILTER_MASK(32'h7F), .FILTER_MATCH(32'h33)) u_f (
    .clock(clock), .resetn(resetn), .rvfi_valid(vF), .rvfi_insn(iF), .rvfi_halt(hF),
    .check(cF), .check_chan(chF), .retire_cnt(cntF), .done(dF), .aborted(aF));
`endif

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the expected strobe pushed at drive time and compare chan and check.
  task automatic sb(input string tag, input logic [1:0] chan, input logic chk_o);
    logic [1:0] e;
    e = exp_q.pop_front();
    chk({tag, ".chan"}, 32'(chan), 32'(e));
    chk({tag, ".check"}, 32'(chk_o), 32'(|e));
    $display("txn %s chan=%b check=%b", tag, chan, chk_o);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".A"}, {22'd0, cntA, dA, aA}, 32'd0);
    chk({tag, ".B"}, {22'd0, cntB, dB, aB}, 32'd0);
    chk({tag, ".C"}, {22'd0, cntC, dC, aC}, 32'd0);
    chk({tag, ".D"}, {22'd0, cntD, dD, aD}, 32'd0);
    chk({tag, ".E"}, {27'd0, cntE, dE, aE}, 32'd0);
  endtask

  initial begin
    // Reset state, and strobe suppressed while resetn is low.
    tick();
    chk_all_zero("rst");
    vA = 1; exp_q.push_back(2'b00); #1 sb("A.in_reset", {1'b0, chA}, cA);
    // IDLE cycle: retirement ignored.
    tick(); resetn = 1;
    exp_q.push_back(2'b00); #1 sb("A.idle", {1'b0, chA}, cA);
    tick(); chk("A.idle_cnt", 32'(cntA), 32'd0);
    exp_q.push_back(2'b00); #1 sb("A.r1", {1'b0, chA}, cA);
    tick(); exp_q.push_back(2'b00); #1 sb("A.r2", {1'b0, chA}, cA);
    tick(); exp_q.push_back(2'b01); #1 sb("A.r3", {1'b0, chA}, cA);
    tick(); chk("A.done", 32'(dA), 32'd1); chk("A.cnt3", 32'(cntA), 32'd3);
    exp_q.push_back(2'b00); #1 sb("A.terminal", {1'b0, chA}, cA);
    tick(); vA = 0; chk("A.cnt_hold", 32'(cntA), 32'd3);

    // B: two channels per cycle, check on channel 0 of the second cycle.
    vB = 2'b11; exp_q.push_back(2'b00); #1 sb("B.c1", chB, cB);
    tick(); exp_q.push_back(2'b01); #1 sb("B.c2", chB, cB);
    tick(); vB = 0;
    chk("B.cnt", 32'(cntB), 32'd4); chk("B.done", 32'(dB), 32'd1); chk("B.aborted", 32'(aB), 32'd0);

    // C: halt on the selected channel still completes the check.
    vC = 2'b11; hC = 2'b10; exp_q.push_back(2'b10); #1 sb("C.halt_sel", chC, cC);
    tick(); vC = 0; hC = 0;
    chk("C.done", 32'(dC), 32'd1); chk("C.aborted", 32'(aC), 32'd0); chk("C.cnt", 32'(cntC), 32'd2);

    // D: halt before depth aborts.
    vD = 1; exp_q.push_back(2'b00); #1 sb("D.r1", {1'b0, chD}, cD);
    tick(); hD = 1; exp_q.push_back(2'b00); #1 sb("D.r2_halt", {1'b0, chD}, cD);
    tick(); vD = 0; hD = 0;
    chk("D.aborted", 32'(aD), 32'd1); chk("D.done", 32'(dD), 32'd0); chk("D.cnt", 32'(cntD), 32'd2);
    vD = 1; exp_q.push_back(2'b00); #1 sb("D.terminal", {1'b0, chD}, cD);
    tick(); vD = 0; chk("D.cnt_hold", 32'(cntD), 32'd2);

    // E: counter saturates at 7 without wrap; no check.
    vE = 1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(2'b00); #1 sb($sformatf("E.r%0d", i + 1), {1'b0, chE}, cE);
      tick();
    end
    vE = 0;
    chk("E.sat", 32'(cntE), 32'd7); chk("E.done", 32'(dE), 32'd0);
    resetn = 0; vE = 1; exp_q.push_back(2'b00); #1 sb("E.in_reset", {1'b0, chE}, cE);
    tick(); vE = 0;
    chk_all_zero("rst2");
    resetn = 1;

    // A: reset mid-count discards progress.
    tick(); vA = 1; exp_q.push_back(2'b00); #1 sb("A2.r1", {1'b0, chA}, cA);
    tick(); exp_q.push_back(2'b00); #1 sb("A2.r2", {1'b0, chA}, cA);
    tick(); chk("A2.cnt2", 32'(cntA), 32'd2); resetn = 0; vA = 0;
    tick(); resetn = 1; chk("A2.cnt_reset", 32'(cntA), 32'd0);
    tick(); vA = 1;
    exp_q.push_back(2'b00); #1 sb("A3.r1", {1'b0, chA}, cA);
    tick(); exp_q.push_back(2'b00); #1 sb("A3.r2", {1'b0, chA}, cA);
    tick(); exp_q.push_back(2'b01); #1 sb("A3.r3", {1'b0, chA}, cA);
    tick(); vA = 0; chk("A3.done", 32'(dA), 32'd1); chk("A3.cnt", 32'(cntA), 32'd3);

`ifdef RVFI_CHECK_SEQ_FILTER_EN
    // F: filter selects only matching instructions; all retirements count.
    vF = 1; iF = 32'h13; exp_q.push_back(2'b00); #1 sb("F.nomatch", {1'b0, chF}, cF);
    tick(); iF = 32'h33; exp_q.push_back(2'b01); #1 sb("F.match", {1'b0, chF}, cF);
    tick(); vF = 0; chk("F.cnt", 32'(cntF), 32'd2); chk("F.done", 32'(dF), 32'd1);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
